// File: rtl/imem_loader_pkg.sv
// Shared definitions for the serial image loaders.
// Holds the loader FSM states and the frame field widths.
package imem_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int CSUM_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-framed, checksummed byte stream
// to the IMEM byte write port; holds the CPU in reset until done.
// Ports: clk, rst (async, high), start, in_valid/in_data/in_ready,
// mem_we/mem_addr/mem_wdata, cpu_hold, done, error.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int BASE  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = $clog2(DEPTH + 1);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CSUM_W-1:0]   acc_q, acc_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;

  logic             xfer;
  logic             armed;
  logic             last;
  logic [LEN_W-1:0] n_rx;

  assign xfer  = in_valid & in_ready;
  assign armed = start &
                 ((state_q == IDLE) |
                  (state_q == DONE) |
                  (state_q == ERR));
  // Full length as it completes on the LEN_LO byte.
  assign n_rx  = {len_q[LEN_W-1:8], in_data};
  assign last  = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR:
        if (start) state_d = LEN_HI;
      LEN_HI:
        if (xfer) state_d = LEN_LO;
      LEN_LO:
        if (xfer) begin
          if (int'(n_rx) > DEPTH)  state_d = ERR;
          else if (n_rx == '0)     state_d = CSUM;
          else                     state_d = DATA;
        end
      DATA:
        if (xfer && last) state_d = CSUM;
      CSUM:
        if (xfer) begin
          if (in_data == acc_q) state_d = DONE;
          else                  state_d = ERR;
        end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == LEN_HI) |
               (state_q == LEN_LO) |
               (state_q == DATA)   |
               (state_q == CSUM);
    done     = (state_q == DONE);
    error    = (state_q == ERR);
    cpu_hold = (state_q != DONE);
  end

  always_comb begin
    len_d   = len_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (armed) begin
      idx_d = '0;
      acc_d = '0;
    end
    if (xfer && state_q == LEN_HI)
      len_d = {in_data, 8'h00};
    if (xfer && state_q == LEN_LO)
      len_d = n_rx;
    if (xfer && state_q == DATA) begin
      we_d    = 1'b1;
      addr_d  = 32'(BASE) + 32'(idx_q);
      wdata_d = in_data;
      acc_d   = acc_q + in_data;
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      len_q   <= len_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
